// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and the hex-digit to ASCII mapping
// used by the LCD hex writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        IDLE,
        ADDR,
        CHARS
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_HI,
        PH_LO,
        PH_WAIT
    } lcd_phase_t;

    localparam logic [7:0] LCD_FUNCSET   = 8'h28;
    localparam logic [7:0] LCD_DISPON    = 8'h0C;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME_ADDR = 8'h80;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] h);
        return (h < 4'd10) ? (8'h30 + {4'h0, h}) : (8'h37 + {4'h0, h});
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one nibble on the 4-bit LCD bus: setup cycle, E_PULSE cycles of E high,
// hold cycle. DB/RS are held for the whole transfer and forced low when idle.
module lcd_nibble_tx #(
    parameter int E_PULSE = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [3:0] i_nibble,
    output logic       o_e,
    output logic       o_rs,
    output logic [3:0] o_db,
    output logic       o_done
);
    localparam int N  = E_PULSE + 2;
    localparam int CW = $clog2(N);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic          r_rs;
    logic [3:0]    r_db;
    logic          r_e;

    // E is registered so the strobe pin never sees decode glitches
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_rs     <= 1'b0;
            r_db     <= 4'h0;
            r_e      <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_rs     <= i_rs;
            r_db     <= i_nibble;
            r_e      <= 1'b0;
        end else if (r_active) begin
            r_e <= (r_cnt < CW'(E_PULSE));
            if (r_cnt == CW'(N - 1))
                r_active <= 1'b0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_e    = r_e;
    assign o_rs   = r_active & r_rs;
    assign o_db   = r_active ? r_db : 4'h0;
    assign o_done = r_active && (r_cnt == CW'(N - 1));

endmodule

// File: rtl/lcd_hex_writer.sv
// Writes a 32-bit word as 8 ASCII hex characters to an HD44780 LCD (4-bit bus),
// including power-up init. Optional macro LCD_AUTO_REFRESH_EN rewrites on Value change.
module lcd_hex_writer
    import lcd_pkg::*;
#(
    parameter int DELAY_INIT = 750000,
    parameter int E_PULSE    = 12,
    parameter int CMD_WAIT   = 2000,
    parameter int CLR_WAIT   = 82000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Value,
    input  logic        Update,
    output logic        LCD_E,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic [3:0]  LCD_DB,
    output logic        Busy
);
    localparam int MAXW = (DELAY_INIT > CLR_WAIT)
                        ? ((DELAY_INIT > CMD_WAIT) ? DELAY_INIT : CMD_WAIT)
                        : ((CLR_WAIT > CMD_WAIT) ? CLR_WAIT : CMD_WAIT);
    localparam int CW = (MAXW > 1) ? $clog2(MAXW) : 1;

    lcd_state_t    r_state, w_state_nx;
    lcd_phase_t    r_phase, w_phase_nx;
    logic [2:0]    r_step, w_step_nx;
    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic [31:0]   r_snap;

    logic       w_go, w_tx_done, w_nib_only, w_last_step, w_wait_end, w_pwr_end;
    logic       w_start_hi, w_start_lo, w_tx_start, w_tx_rs;
    logic [7:0] w_byte_cur, w_tx_byte;
    logic [3:0] w_tx_nib;
    logic       w_is_clear;

    // Byte sent at a given step: fixed init/address bytes, or a snapshot digit
    function automatic logic [7:0] step_byte(input lcd_state_t s, input logic [2:0] st,
                                             input logic [31:0] snap);
        logic [31:0] sh;
        sh = snap << {st, 2'b00};
        case (s)
            INIT: begin
                case (st)
                    3'd0, 3'd1, 3'd2: return 8'h30;
                    3'd3:             return 8'h20;
                    3'd4:             return LCD_FUNCSET;
                    3'd5:             return LCD_DISPON;
                    3'd6:             return LCD_ENTRY;
                    default:          return LCD_CLEAR;
                endcase
            end
            ADDR:    return LCD_HOME_ADDR;
            CHARS:   return hex_to_ascii(sh[31:28]);
            default: return 8'h00;
        endcase
    endfunction

`ifdef LCD_AUTO_REFRESH_EN
    assign w_go = Update | r_pending | (Value != r_snap);
`else
    assign w_go = Update | r_pending;
`endif

    assign w_byte_cur  = step_byte(r_state, r_step, r_snap);
    assign w_nib_only  = (r_state == INIT) && (r_step < 3'd4);
    assign w_last_step = (r_state == ADDR) || (r_step == 3'd7);
    assign w_is_clear  = (w_byte_cur == LCD_CLEAR) && !w_nib_only;
    assign w_wait_end  = (r_phase == PH_WAIT) &&
                         (r_cnt == (w_is_clear ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1)));
    assign w_pwr_end   = (r_state == PWRUP) && (r_cnt == CW'(DELAY_INIT - 1));
    assign LCD_RW      = 1'b0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= PWRUP;
            r_phase <= PH_HI;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_step  <= w_step_nx;
        end
    end

    // Wait counter restarts at every phase boundary so it never wraps
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_snap    <= 32'h0;
        end else begin
            if (w_state_nx != r_state || w_phase_nx != r_phase || w_step_nx != r_step)
                r_cnt <= '0;
            else if (r_state == PWRUP || r_phase == PH_WAIT)
                r_cnt <= r_cnt + 1'b1;

            if (r_state == IDLE && w_go) begin
                r_pending <= 1'b0;
                r_snap    <= Value;
            end else if (Update) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_step_nx  = r_step;
        w_start_hi = 1'b0;
        w_start_lo = 1'b0;
        case (r_state)
            PWRUP: begin
                if (w_pwr_end) begin
                    w_state_nx = INIT;
                    w_step_nx  = 3'd0;
                    w_phase_nx = PH_HI;
                    w_start_hi = 1'b1;
                end
            end
            IDLE: begin
                if (w_go) begin
                    w_state_nx = ADDR;
                    w_step_nx  = 3'd0;
                    w_phase_nx = PH_HI;
                    w_start_hi = 1'b1;
                end
            end
            default: begin
                case (r_phase)
                    PH_HI: begin
                        if (w_tx_done) begin
                            if (w_nib_only) begin
                                w_phase_nx = PH_WAIT;
                            end else begin
                                w_phase_nx = PH_LO;
                                w_start_lo = 1'b1;
                            end
                        end
                    end
                    PH_LO: begin
                        if (w_tx_done)
                            w_phase_nx = PH_WAIT;
                    end
                    default: begin
                        if (w_wait_end) begin
                            w_phase_nx = PH_HI;
                            if (!w_last_step) begin
                                w_step_nx  = r_step + 3'd1;
                                w_start_hi = 1'b1;
                            end else if (r_state == ADDR) begin
                                w_state_nx = CHARS;
                                w_step_nx  = 3'd0;
                                w_start_hi = 1'b1;
                            end else begin
                                w_state_nx = IDLE;
                                w_step_nx  = 3'd0;
                            end
                        end
                    end
                endcase
            end
        endcase
    end

    // A new step's high nibble is launched in the same cycle the step begins
    always_comb begin
        w_tx_byte = w_byte_cur;
        w_tx_rs   = (r_state == CHARS);
        if (w_start_hi) begin
            w_tx_byte = step_byte(w_state_nx, w_step_nx, r_snap);
            w_tx_rs   = (w_state_nx == CHARS);
        end
        w_tx_start = w_start_hi | w_start_lo;
        w_tx_nib   = w_start_hi ? w_tx_byte[7:4] : w_tx_byte[3:0];
        Busy       = (r_state != IDLE);
    end

    lcd_nibble_tx #(.E_PULSE(E_PULSE)) u_tx (
        .CLK      (CLK),
        .RST      (RST),
        .i_start  (w_tx_start),
        .i_rs     (w_tx_rs),
        .i_nibble (w_tx_nib),
        .o_e      (LCD_E),
        .o_rs     (LCD_RS),
        .o_db     (LCD_DB),
        .o_done   (w_tx_done)
    );

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Bench for lcd_hex_writer: a per-cycle expected-bus queue model plus literal checks
// of the decoded nibble stream, init timing and write length.
module tb_lcd_hex_writer;

    localparam int DI   = 20;
    localparam int EP   = 2;
    localparam int CMDW = 4;
    localparam int CLRW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        Update;
    logic [31:0] Value;
    logic        LCD_E, LCD_RS, LCD_RW, Busy;
    logic [3:0]  LCD_DB;

    lcd_hex_writer #(
        .DELAY_INIT (DI),
        .E_PULSE    (EP),
        .CMD_WAIT   (CMDW),
        .CLR_WAIT   (CLRW)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .Value  (Value),
        .Update (Update),
        .LCD_E  (LCD_E),
        .LCD_RS (LCD_RS),
        .LCD_RW (LCD_RW),
        .LCD_DB (LCD_DB),
        .Busy   (Busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       e;
        logic       chk;
        logic       rs;
        logic [3:0] db;
    } ent_t;

    localparam ent_t IDLE_ENT = '{busy: 1'b0, e: 1'b0, chk: 1'b1, rs: 1'b0, db: 4'h0};

    ent_t       q_exp[$];
    logic [4:0] cap[$];
    logic       m_pending = 1'b0;
    int         n_checks = 0, n_fail = 0;
    int         cyc = 0, rel_cyc = 0, first_e = -1, busy_fall = -1, n_busy = 0;
    logic       prev_e = 1'b0;
    string      HEXS = "0123456789ABCDEF";

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [3:0] n);
        return HEXS[int'(n)];
    endfunction

    task automatic push_wait(input int n);
        for (int k = 0; k < n; k++)
            q_exp.push_back('{busy: 1'b1, e: 1'b0, chk: 1'b0, rs: 1'b0, db: 4'h0});
    endtask

    task automatic push_nib(input logic rs, input logic [3:0] d);
        for (int k = 0; k < EP + 2; k++)
            q_exp.push_back('{busy: 1'b1, e: (k >= 1 && k <= EP), chk: 1'b1, rs: rs, db: d});
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        push_nib(rs, b[7:4]);
        push_nib(rs, b[3:0]);
        push_wait((b == 8'h01) ? CLRW : CMDW);
    endtask

    task automatic push_init();
        push_wait(DI);
        push_nib(1'b0, 4'h3); push_wait(CMDW);
        push_nib(1'b0, 4'h3); push_wait(CMDW);
        push_nib(1'b0, 4'h3); push_wait(CMDW);
        push_nib(1'b0, 4'h2); push_wait(CMDW);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h01);
    endtask

    // The accepting IDLE cycle itself, then address byte and 8 digits MSD first
    task automatic push_idle_write(input logic [31:0] v);
        q_exp.push_back(IDLE_ENT);
        push_byte(1'b0, 8'h80);
        for (int i = 7; i >= 0; i--)
            push_byte(1'b1, ascii_of(v[4*i +: 4]));
    endtask

    always @(negedge clk) begin
        ent_t x;
        if (rst) begin
            check("rst_E", LCD_E, 1'b0);
            check("rst_DB", LCD_DB, 4'h0);
            check("rst_RS", LCD_RS, 1'b0);
            check("rst_Busy", Busy, 1'b1);
            prev_e = 1'b0;
        end else begin
            if (q_exp.size() == 0 && m_pending) begin
                m_pending = 1'b0;
                push_idle_write(Value);
            end
            if (q_exp.size() == 0) x = IDLE_ENT;
            else x = q_exp.pop_front();
            check("E", LCD_E, x.e);
            check("Busy", Busy, x.busy);
            check("RW", LCD_RW, 1'b0);
            if (x.chk) begin
                check("RS", LCD_RS, x.rs);
                check("DB", LCD_DB, x.db);
            end
            if (LCD_E && !prev_e) begin
                cap.push_back({LCD_RS, LCD_DB});
                if (first_e < 0) first_e = cyc;
            end
            if (!Busy && busy_fall < 0) busy_fall = cyc;
            if (Busy) n_busy++;
            prev_e = LCD_E;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst       = 1'b0;
        rel_cyc   = cyc;
        first_e   = -1;
        busy_fall = -1;
        push_init();
    endtask

    task automatic pulse_update(input logic [31:0] v);
        Value  = v;
        Update = 1'b1;
        if (q_exp.size() == 0) push_idle_write(v);
        else m_pending = 1'b1;
        step(1);
        Update = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q_exp.size() != 0 || m_pending || Busy) && k < 3000) begin
            step(1);
            k++;
        end
        check("idle_timeout", (k < 3000), 1'b1);
        step(5);
    endtask

    task automatic check_init(input string nm);
        logic [4:0] ei [12];
        ei = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
        check({nm, "_count"}, cap.size(), 12);
        for (int i = 0; i < 12; i++)
            check($sformatf("%s_nib%0d", nm, i), (cap.size() > i) ? cap[i] : 5'h1F, ei[i]);
    endtask

    task automatic check_bytes(input string nm, input int base, input logic [8:0] e [9]);
        for (int i = 0; i < 9; i++) begin
            logic [8:0] got;
            got = 9'h1FF;
            if (cap.size() >= base + 2*i + 2)
                got = {cap[base+2*i][4], cap[base+2*i][3:0], cap[base+2*i+1][3:0]};
            check($sformatf("%s_byte%0d", nm, i), got, e[i]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] e9 [9];
        rst = 1'b1; Update = 1'b0; Value = 32'h0;
        step(3);

        // Power-up and init sequence timing
        release_reset();
        wait_idle();
        check("init_first_E_delay", first_e - rel_cyc, 21);
        check("init_busy_len", busy_fall - rel_cyc, 106);
        check_init("init");

        // Basic write
        cap.delete(); n_busy = 0;
        pulse_update(32'h1234ABCD);
        wait_idle();
        check("w1_busy_cycles", n_busy, 108);
        check("w1_count", cap.size(), 18);
        e9 = '{9'h080, 9'h131, 9'h132, 9'h133, 9'h134, 9'h141, 9'h142, 9'h143, 9'h144};
        check_bytes("w1", 0, e9);

        // Two Updates mid-write collapse to one follow-up using the new Value
        cap.delete();
        pulse_update(32'h0);
        step(20);
        pulse_update(32'hDEADBEEF);
        step(30);
        pulse_update(32'hDEADBEEF);
        wait_idle();
        check("pend_count", cap.size(), 36);
        e9 = '{9'h080, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130};
        check_bytes("pend_first", 0, e9);
        e9 = '{9'h080, 9'h144, 9'h145, 9'h141, 9'h144, 9'h142, 9'h145, 9'h145, 9'h146};
        check_bytes("pend_second", 18, e9);

        // All-F word
        cap.delete();
        pulse_update(32'hFFFFFFFF);
        wait_idle();
        e9 = '{9'h080, 9'h146, 9'h146, 9'h146, 9'h146, 9'h146, 9'h146, 9'h146, 9'h146};
        check_bytes("wf", 0, e9);

        // Asynchronous reset during the 3rd character, with a pending Update
        cap.delete();
        pulse_update(32'h1234ABCD);
        step(5);
        pulse_update(32'h1234ABCD);
        begin
            int k = 0;
            while (cap.size() < 7 && k < 200) begin
                @(negedge clk);
                k++;
            end
            #1;
            check("rst_wait_timeout", (k < 200), 1'b1);
        end
        check("pre_rst_E", LCD_E, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_E", LCD_E, 1'b0);
        check("async_rst_DB", LCD_DB, 4'h0);
        check("async_rst_Busy", Busy, 1'b1);
        q_exp.delete();
        m_pending = 1'b0;
        Value = 32'h0;
        cap.delete();
        step(2);
        release_reset();
        wait_idle();
        check("reinit_busy_len", busy_fall - rel_cyc, 106);
        check_init("reinit");

        // Value change in IDLE without Update
        cap.delete();
        Value = 32'h5;
`ifdef LCD_AUTO_REFRESH_EN
        if (q_exp.size() == 0) push_idle_write(32'h5);
`endif
        step(40);
        wait_idle();
`ifdef LCD_AUTO_REFRESH_EN
        check("auto_count", cap.size(), 18);
        e9 = '{9'h080, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130, 9'h130, 9'h135};
        check_bytes("auto", 0, e9);
`else
        check("noauto_count", cap.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
